// File: rtl/seq_run_det_if.sv
// rtl/seq_run_det_if.sv - word stream and match report bundle for seq_run_det
interface seq_run_det_if #(
  parameter int W  = 4,
  parameter int N  = 3,
  parameter int CW = 16
);
  localparam int MW = $clog2(W + 1);
  localparam int RW = $clog2(N + 1);

  logic          en;
  logic          clr;
  logic [W-1:0]  d;
  logic          hit;
  logic [MW-1:0] mcnt;
  logic [CW-1:0] total;
  logic [RW-1:0] run;

  modport master (output en, clr, d, input hit, mcnt, total, run);
  modport slave  (input en, clr, d, output hit, mcnt, total, run);
endinterface

// File: rtl/seq_run_det.sv
// rtl/seq_run_det.sv - run-of-N-ones detector over a word-sliced serial stream
module seq_run_det #(
  parameter int W       = 4,
  parameter int N       = 3,
  parameter bit OVERLAP = 1'b1,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_b,
  seq_run_det_if.slave  bus
);
  localparam int MW = $clog2(W + 1);
  localparam int RW = $clog2(N + 1);
  // Sum width wide enough for either operand plus a carry, so saturation is exact.
  localparam int SW = ((CW > MW) ? CW : MW) + 1;
  localparam logic [RW-1:0] N_V     = RW'(N);
  localparam logic [CW-1:0] TOT_MAX = {CW{1'b1}};

  logic          r_hit;
  logic [MW-1:0] r_mcnt;
  logic [CW-1:0] r_total;
  logic [RW-1:0] r_run;

  logic [RW-1:0] w_run_nxt;
  logic [MW-1:0] w_cnt;
  logic [SW-1:0] w_sum;
  logic [CW-1:0] w_total_nxt;

  // Walk the word oldest-to-newest, carrying the run length from the previous word.
  always_comb begin
    w_run_nxt = r_run;
    w_cnt     = '0;
    for (int k = 0; k < W; k++) begin
      if (bus.d[k]) begin
        if (w_run_nxt != N_V) w_run_nxt = w_run_nxt + RW'(1);
        if (w_run_nxt == N_V) begin
          w_cnt = w_cnt + MW'(1);
          if (!OVERLAP) w_run_nxt = '0;
        end
      end else begin
        w_run_nxt = '0;
      end
    end
  end

  // Saturating accumulation of this word's matches into the running total.
  always_comb begin
    w_sum       = SW'(r_total) + SW'(w_cnt);
    w_total_nxt = (w_sum > SW'(TOT_MAX)) ? TOT_MAX : w_sum[CW-1:0];
  end

  // State and report registers; clear beats enable and drops the presented word.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_hit   <= 1'b0;
      r_mcnt  <= '0;
      r_total <= '0;
      r_run   <= '0;
    end else if (bus.clr) begin
      r_hit   <= 1'b0;
      r_mcnt  <= '0;
      r_total <= '0;
      r_run   <= '0;
    end else if (bus.en) begin
      r_hit   <= (w_cnt != '0);
      r_mcnt  <= w_cnt;
      r_total <= w_total_nxt;
      r_run   <= w_run_nxt;
    end else begin
      r_hit   <= 1'b0;
      r_mcnt  <= '0;
    end
  end

  assign bus.hit   = r_hit;
  assign bus.mcnt  = r_mcnt;
  assign bus.total = r_total;
  assign bus.run   = r_run;
endmodule

// File: tb/tb_seq_run_det.sv
// tb/tb_seq_run_det.sv - scoreboard bench for seq_run_det in three configurations
module tb_seq_run_det;
  localparam int N = 3;

  typedef struct {
    int hit;
    int mcnt;
    int total;
    int run;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  // A: defaults, B: non-overlapping, C: overlapping with a 3-bit total
  seq_run_det_if #(.W(4), .N(N), .CW(16)) ia ();
  seq_run_det_if #(.W(4), .N(N), .CW(16)) ib ();
  seq_run_det_if #(.W(4), .N(N), .CW(3))  ic ();

  seq_run_det #(.W(4), .N(N), .OVERLAP(1'b1), .CW(16)) u_a (.clk(clk), .rst_b(rst_b), .bus(ia));
  seq_run_det #(.W(4), .N(N), .OVERLAP(1'b0), .CW(16)) u_b (.clk(clk), .rst_b(rst_b), .bus(ib));
  seq_run_det #(.W(4), .N(N), .OVERLAP(1'b1), .CW(3))  u_c (.clk(clk), .rst_b(rst_b), .bus(ic));

  int n_total = 0;
  int n_bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Reference state: trailing ones in the stream since reset/clear, per-config totals.
  int ones = 0;
  int tot[3];
  int ov[3]   = '{1, 0, 1};
  int tmax[3] = '{65535, 65535, 7};

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_set(input string tag, input exp_t e, input int h, input int m, input int t, input int r);
    chk({tag, ".hit"}, h, e.hit);
    chk({tag, ".mcnt"}, m, e.mcnt);
    chk({tag, ".total"}, t, e.total);
    chk({tag, ".run"}, r, e.run);
  endtask

  function automatic int run_of(input int i);
    if (ov[i] != 0) return (ones < N) ? ones : N;
    return ones % N;
  endfunction

  task automatic model(input bit en, input bit clr, input logic [3:0] dv);
    exp_t e[3];
    int   m[3];
    for (int i = 0; i < 3; i++) m[i] = 0;
    if (clr) begin
      ones = 0;
      for (int i = 0; i < 3; i++) tot[i] = 0;
    end else if (en) begin
      for (int b = 0; b < 4; b++) begin
        ones = dv[b] ? ones + 1 : 0;
        for (int i = 0; i < 3; i++) begin
          if (ov[i] != 0) begin
            if (ones >= N) m[i]++;
          end else begin
            if (ones > 0 && ones % N == 0) m[i]++;
          end
        end
      end
      for (int i = 0; i < 3; i++) tot[i] = (tot[i] + m[i] > tmax[i]) ? tmax[i] : tot[i] + m[i];
    end
    for (int i = 0; i < 3; i++) begin
      e[i].hit   = (m[i] != 0) ? 1 : 0;
      e[i].mcnt  = m[i];
      e[i].total = tot[i];
      e[i].run   = run_of(i);
    end
    q0.push_back(e[0]);
    q1.push_back(e[1]);
    q2.push_back(e[2]);
  endtask

  task automatic step(input bit en, input bit clr, input logic [3:0] dv);
    @(negedge clk);
    ia.en = en; ia.clr = clr; ia.d = dv;
    ib.en = en; ib.clr = clr; ib.d = dv;
    ic.en = en; ic.clr = clr; ic.d = dv;
    model(en, clr, dv);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".A.hit"}, int'(ia.hit), 0);
    chk({tag, ".A.mcnt"}, int'(ia.mcnt), 0);
    chk({tag, ".A.total"}, int'(ia.total), 0);
    chk({tag, ".A.run"}, int'(ia.run), 0);
    chk({tag, ".B.run"}, int'(ib.run), 0);
    chk({tag, ".C.total"}, int'(ic.total), 0);
  endtask

  // Monitor: registered outputs are presented every cycle; compare just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp_set("A", e, int'(ia.hit), int'(ia.mcnt), int'(ia.total), int'(ia.run));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp_set("B", e, int'(ib.hit), int'(ib.mcnt), int'(ib.total), int'(ib.run));
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        cmp_set("C", e, int'(ic.hit), int'(ic.mcnt), int'(ic.total), int'(ic.run));
      end
    end
  end

  initial begin
    logic [3:0] dv;
    for (int i = 0; i < 3; i++) tot[i] = 0;
    ia.en = 1'b0; ia.clr = 1'b0; ia.d = '0;
    ib.en = 1'b0; ib.clr = 1'b0; ib.d = '0;
    ic.en = 1'b0; ic.clr = 1'b0; ic.d = '0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    check_zero("reset");

    // Default-mode walk including a run crossing a word boundary
    step(1'b1, 1'b0, 4'b0111);
    step(1'b1, 1'b0, 4'b1111);
    step(1'b1, 1'b0, 4'b0001);

    // Mode comparison and 3-bit saturation from a clean state
    step(1'b0, 1'b1, 4'b0000);
    step(1'b1, 1'b0, 4'b1111);
    step(1'b1, 1'b0, 4'b1111);
    step(1'b1, 1'b0, 4'b1111);

    // Idle cycle holds state; clear with enable drops the word
    step(1'b0, 1'b0, 4'b1111);
    step(1'b1, 1'b1, 4'b1111);

    // Asynchronous reset in the middle of a run
    step(1'b1, 1'b0, 4'b1100);
    @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    check_zero("async_rst");
    rst_b = 1'b1;
    ones = 0;
    for (int i = 0; i < 3; i++) tot[i] = 0;
    step(1'b1, 1'b0, 4'b0001);

    // Sweep of every word value from run=0
    for (int v = 0; v < 16; v++) begin
      dv = 4'(v);
      step(1'b0, 1'b1, 4'b0000);
      step(1'b1, 1'b0, dv);
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      dv = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 24) == 0), dv);
    end

    step(1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    #3;
    chk("drain.q0", q0.size(), 0);
    chk("drain.q1", q1.size(), 0);
    chk("drain.q2", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
